// File: rtl/preset_release_seq_if.sv
// Request/preset bundle between bank control logic and the preset sequencer.
// The requester side is the master; the sequencer is the slave.
interface preset_release_seq_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  ack;
  logic [N-1:0]  sn_n;
  logic [N-1:0]  ck_en;
  logic          busy;
  logic [IW-1:0] gnt_id;

  modport master (output req, input ack, sn_n, ck_en, busy, gnt_id);
  modport slave  (input req, output ack, sn_n, ck_en, busy, gnt_id);
endinterface

// File: rtl/preset_release_seq.sv
// Round-robin sequencer for active-low async presets of N flop banks.
// Each grant holds SN low for PULSE_CYC cycles, then gates the bank clock for REC_CYC more.
module preset_release_seq #(
  parameter int unsigned N         = 4,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned REC_CYC   = 2,
  parameter int unsigned CW        = 4
) (
  input  logic                 ck,
  input  logic                 rst,
  preset_release_seq_if.slave  bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MAX_CYC = (PULSE_CYC > REC_CYC) ? PULSE_CYC : REC_CYC;

  if (N < 2 || N > 16) begin : g_bad_n
    $fatal(1, "preset_release_seq: N must be in 2..16");
  end
  if (PULSE_CYC == 0) begin : g_bad_pulse
    $fatal(1, "preset_release_seq: PULSE_CYC must be >= 1");
  end
  if (REC_CYC == 0) begin : g_bad_rec
    $fatal(1, "preset_release_seq: REC_CYC must be >= 1");
  end
  if ((64'd1 << CW) <= 64'(MAX_CYC)) begin : g_bad_cw
    $fatal(1, "preset_release_seq: CW too narrow for PULSE_CYC/REC_CYC");
  end

  typedef enum logic [1:0] {IDLE, ASSERT, RECOVER, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [N-1:0]  sn_n_q, sn_n_d;
  logic [N-1:0]  ck_en_q, ck_en_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          busy_q, busy_d;

  logic [IW-1:0] pick_c;
  logic [N-1:0]  pick_oh_c;
  logic [N-1:0]  gnt_oh_c;

  // First pending request at or after the round-robin pointer, wrapping.
  always_comb begin
    logic found;
    int unsigned j;
    pick_c = rr_q;
    found  = 1'b0;
    j      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(rr_q) + i;
      if (j >= N) j = j - N;
      if (!found && bus.req[IW'(j)]) begin
        found  = 1'b1;
        pick_c = IW'(j);
      end
    end
  end

  assign pick_oh_c = N'(1) << pick_c;
  assign gnt_oh_c  = N'(1) << gnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    sn_n_d  = sn_n_q;
    ck_en_d = ck_en_q;
    ack_d   = '0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = pick_c;
          cnt_d   = CW'(PULSE_CYC - 1);
          sn_n_d  = ~pick_oh_c;
          ck_en_d = ~pick_oh_c;
          busy_d  = 1'b1;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (cnt_q == '0) begin
          sn_n_d  = '1;
          cnt_d   = CW'(REC_CYC - 1);
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          ck_en_d = '1;
          ack_d   = gnt_oh_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        // req is deliberately ignored here so the requester can drop it after ack.
        busy_d  = 1'b0;
        rr_d    = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rr_q    <= '0;
      sn_n_q  <= '1;
      ck_en_q <= '1;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      sn_n_q  <= sn_n_d;
      ck_en_q <= ck_en_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sn_n   = sn_n_q;
  assign bus.ck_en  = ck_en_q;
  assign bus.ack    = ack_q;
  assign bus.busy   = busy_q;
  assign bus.gnt_id = gnt_q;
endmodule
